// File: rtl/seg_scan_controller.sv
// Four-digit seven-segment scan scheduler: double-buffered value, rotating active-low anode,
// per-digit nibble/blank generation under a button-driven display mode FSM.
module seg_scan_controller #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic        load,
  input  logic        mode_btn,
  output logic [3:0]  anode,
  output logic [3:0]  nibble,
  output logic        blank,
  output logic [1:0]  digit_sel,
  output logic [1:0]  mode,
  output logic        pending,
  output logic        frame_tick
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_LZB    = 2'b10,
    MODE_TEST   = 2'b11
  } mode_t;

  mode_t mode_q, mode_d;

  logic [PW-1:0] presc;
  logic [1:0]    scan_idx;
  logic [15:0]   active_buf, pending_buf;
  logic          pending_q;
  logic          frame_seen;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic          tick, boundary, blink_wrap, phase_next;
  logic [1:0]    next_idx;
  logic [15:0]   disp_buf;
  logic [3:0]    digit_val, nibble_d;
  logic          blank_d;

  assign tick       = (presc == PW'(REFRESH_DIV - 1));
  assign next_idx   = scan_idx + 2'd1;
  assign boundary   = tick && (scan_idx == 2'd3);
  // The very first boundary after reset opens frame 0, so it does not advance the blink count.
  assign blink_wrap = boundary && frame_seen && (blink_cnt == BW'(BLINK_FRAMES - 1));
  assign phase_next = blink_wrap ? ~blink_phase : blink_phase;
  // A pending value applied at this boundary must already drive digit 0 of the new frame.
  assign disp_buf   = (boundary && pending_q) ? pending_buf : active_buf;
  assign digit_val  = disp_buf[{next_idx, 2'b00} +: 4];

  always_comb begin
    mode_d = mode_q;
    if (mode_btn) begin
      unique case (mode_q)
        MODE_NORMAL: mode_d = MODE_BLINK;
        MODE_BLINK:  mode_d = MODE_LZB;
        MODE_LZB:    mode_d = MODE_TEST;
        MODE_TEST:   mode_d = MODE_NORMAL;
      endcase
    end
  end

  always_comb begin
    nibble_d = digit_val;
    blank_d  = 1'b0;
    unique case (mode_q)
      MODE_NORMAL: blank_d = 1'b0;
      MODE_BLINK:  blank_d = phase_next;
      MODE_LZB:    blank_d = (next_idx != 2'd0) && ((disp_buf >> {next_idx, 2'b00}) == 16'h0);
      MODE_TEST: begin
        nibble_d = 4'h8;
        blank_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q      <= MODE_NORMAL;
      presc       <= '0;
      scan_idx    <= 2'd3;
      active_buf  <= 16'h0;
      pending_buf <= 16'h0;
      pending_q   <= 1'b0;
      frame_seen  <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      anode       <= 4'b1111;
      nibble      <= 4'h0;
      blank       <= 1'b1;
      digit_sel   <= 2'd3;
      frame_tick  <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      presc      <= tick ? '0 : presc + PW'(1);
      frame_tick <= boundary;
      if (tick) begin
        scan_idx  <= next_idx;
        anode     <= ~(4'b0001 << next_idx);
        nibble    <= nibble_d;
        blank     <= blank_d;
        digit_sel <= next_idx;
      end
      if (boundary) begin
        frame_seen  <= 1'b1;
        blink_phase <= phase_next;
        if (frame_seen) blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
        if (pending_q) begin
          active_buf <= pending_buf;
          pending_q  <= 1'b0;
        end
      end
      // A load on the boundary cycle wins over the clear above.
      if (load) begin
        pending_buf <= digits_in;
        pending_q   <= 1'b1;
      end
    end
  end

  assign mode    = mode_q;
  assign pending = pending_q;

endmodule
